// File: rtl/uart_transmit.sv
// rtl/uart_transmit.sv - buffered 8N1 UART transmitter, LSB first, FIFO-fed
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame).
module uart_transmit #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic       i_DataValid,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Ready,
  output logic       o_Tx_Serial,
  output logic       o_Active,
  output logic       o_Done,
  output logic       o_Overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT  = FIFO_DEPTH[AW:0];

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state, state_next;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr, count, count_next;
  logic            push, pop, empty;
  logic [BW-1:0]   baud;
  logic            baud_last;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
`ifdef UART_TX_PARITY_EN
  logic            par_bit;
`endif

  assign push       = i_DataValid && o_Ready;
  assign count      = wr_ptr - rd_ptr;
  assign empty      = (count == '0);
  assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign baud_last  = (baud == BAUD_LAST);

  // Storage is not reset; emptiness is defined by the pointers alone.
  always_ff @(posedge i_CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_Tx_Byte;
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_Ready    <= 1'b1;
      o_Overflow <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + {{AW{1'b0}}, push};
      rd_ptr     <= rd_ptr + {{AW{1'b0}}, pop};
      o_Ready    <= (count_next != FULL_CNT);
      o_Overflow <= i_DataValid && !o_Ready;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: if (baud_last) state_next = DATA;
      DATA: begin
        if (baud_last && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_last) state_next = STOP;
`endif
      STOP: begin
        if (baud_last) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line outputs are registered from the current state, so the line lags the FSM by one clock.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state       <= IDLE;
      baud        <= '0;
      bit_idx     <= 3'd0;
      shift       <= 8'h00;
`ifdef UART_TX_PARITY_EN
      par_bit     <= 1'b0;
`endif
      o_Tx_Serial <= 1'b1;
      o_Active    <= 1'b0;
      o_Done      <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE || baud_last) baud <= '0;
      else                            baud <= baud + BW'(1);
      if (pop) begin
        shift   <= mem[rd_ptr[AW-1:0]];
        bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
        par_bit <= ^mem[rd_ptr[AW-1:0]];
`endif
      end else if (state == DATA && baud_last) begin
        shift   <= {1'b0, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      case (state)
        START:   o_Tx_Serial <= 1'b0;
        DATA:    o_Tx_Serial <= shift[0];
`ifdef UART_TX_PARITY_EN
        PARITY:  o_Tx_Serial <= par_bit;
`endif
        default: o_Tx_Serial <= 1'b1;
      endcase
      o_Active <= (state != IDLE);
      o_Done   <= (state == STOP) && baud_last;
    end
  end

endmodule
